// File: rtl/gobang_pkg.sv
// Shared gobang types: 15x15 board encoding, score limits and score-arbiter FSM states.
package gobang_pkg;

  localparam int unsigned N_CELLS    = 225;
  localparam int unsigned CELL_W     = 2;
  localparam int unsigned BOARD_BITS = N_CELLS * CELL_W;
  localparam int unsigned SCORE_W    = 32;

  // Cell c of a board lives at bits [c*2 +: 2].
  typedef logic [N_CELLS-1:0][CELL_W-1:0] board_t;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd0;
  localparam logic [CELL_W-1:0] CELL_BLACK = 2'd1;
  localparam logic [CELL_W-1:0] CELL_WHITE = 2'd2;

  localparam logic signed [SCORE_W-1:0] SCORE_MAX = 32'h7FFF_FFFF;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = 32'h8000_0001;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/score_arbiter_if.sv
// Requester-side bus of the score arbiter: requests, boards and turns in; grants and results out.
interface score_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SCORE_W = 32
);
  import gobang_pkg::*;

  logic [N_REQ-1:0]            req;
  logic [N_REQ*BOARD_BITS-1:0] board;
  logic [N_REQ-1:0]            turn;
  logic [N_REQ-1:0]            grant;
  logic [N_REQ-1:0]            done;
  logic signed [SCORE_W-1:0]   score;

  modport master (output req, board, turn, input grant, done, score);
  modport slave  (input req, board, turn, output grant, done, score);

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant_c,
  output logic                     o_found_c
);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] idx;

  always_comb begin
    o_grant_c = '0;
    o_found_c = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(i_ptr) + i) % N_REQ);
      if (!o_found_c && i_req[idx]) begin
        o_grant_c[idx] = 1'b1;
        o_found_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// Shares one Score unit among N_REQ search nodes: round-robin grant, start pulse, result return.
// Optional watchdog on the Score unit is enabled by defining SCORE_ARB_TIMEOUT_EN.
module score_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SCORE_W     = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  score_arbiter_if.slave            arb,
  output logic                      o_sc_start,
  output gobang_pkg::board_t        o_sc_board,
  output logic                      o_sc_turn,
  input  logic signed [SCORE_W-1:0] i_sc_score,
  input  logic                      i_sc_finish,
  output logic                      o_timeout
);
  import gobang_pkg::*;

  localparam int unsigned PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("score_arbiter: unsupported parameter set");
  end

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [N_REQ-1:0]          grant_q, grant_d;
  logic [N_REQ-1:0]          done_q, done_d;
  logic signed [SCORE_W-1:0] score_q, score_d;
  logic                      sc_start_q, sc_start_d;
  board_t                    sc_board_q, sc_board_d;
  logic                      sc_turn_q, sc_turn_d;
  logic                      fin_q, fin_d;
  logic signed [SCORE_W-1:0] res_q, res_d;

  logic [N_REQ-1:0] pick_oh;
  logic             pick_found;
  logic [PTR_W-1:0] g_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req     (arb.req),
    .i_ptr     (ptr_q),
    .o_grant_c (pick_oh),
    .o_found_c (pick_found)
  );

  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) g_idx = PTR_W'(i);
    end
  end

`ifdef SCORE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Finish and score are registered first; only a finish seen while waiting is accepted.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    done_d     = '0;
    score_d    = score_q;
    sc_start_d = 1'b0;
    sc_board_d = sc_board_q;
    sc_turn_d  = sc_turn_q;
    fin_d      = (state_q == ARB_WAIT) && i_sc_finish && !fin_q;
    res_d      = i_sc_finish ? i_sc_score : res_q;
`ifdef SCORE_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_oh;
          sc_board_d = arb.board[32'(g_idx)*BOARD_BITS +: BOARD_BITS];
          sc_turn_d  = arb.turn[g_idx];
          sc_start_d = 1'b1;
          ptr_d      = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
`ifdef SCORE_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ARB_WAIT: begin
        if (fin_q) begin
          score_d = res_q;
          done_d  = grant_q;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
`ifdef SCORE_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          score_d   = '0;
          done_d    = grant_q;
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      score_q    <= '0;
      sc_start_q <= 1'b0;
      sc_board_q <= '0;
      sc_turn_q  <= 1'b0;
      fin_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      score_q    <= score_d;
      sc_start_q <= sc_start_d;
      sc_board_q <= sc_board_d;
      sc_turn_q  <= sc_turn_d;
      fin_q      <= fin_d;
      res_q      <= res_d;
    end
  end

`ifdef SCORE_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign arb.grant  = grant_q;
  assign arb.done   = done_q;
  assign arb.score  = score_q;
  assign o_sc_start = sc_start_q;
  assign o_sc_board = sc_board_q;
  assign o_sc_turn  = sc_turn_q;

endmodule

// File: tb/tb_score_arbiter.sv
// Randomized self-checking bench for score_arbiter against a transaction-level rotation model.
module tb_score_arbiter;
  import gobang_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 32;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  score_arbiter_if #(.N_REQ(N), .SCORE_W(SW)) arb_if ();

  logic                 sc_start;
  board_t               sc_board;
  logic                 sc_turn;
  logic signed [SW-1:0] sc_score;
  logic                 sc_finish;
  logic                 timeout;

  score_arbiter #(.N_REQ(N), .SCORE_W(SW), .TIMEOUT_CYC(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .arb         (arb_if),
    .o_sc_start  (sc_start),
    .o_sc_board  (sc_board),
    .o_sc_turn   (sc_turn),
    .i_sc_score  (sc_score),
    .i_sc_finish (sc_finish),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  board_t         board_m [N];
  logic [N-1:0]   turn_m;
  logic [N-1:0]   req_m;

  for (genvar k = 0; k < N; k++) begin : g_board
    assign arb_if.board[k*BOARD_BITS +: BOARD_BITS] = board_m[k];
  end
  assign arb_if.req  = req_m;
  assign arb_if.turn = turn_m;

  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   ptr_m    = 0;
  logic signed [SW-1:0] score_m  = '0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic board_t rand_board();
    board_t b;
    for (int c = 0; c < int'(N_CELLS); c++) b[c] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  // Reference rotation: first pending requester at or after the pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < int'(N); i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Entered on a negedge with the arbiter idle; ends on the negedge of the done cycle.
  task automatic txn(input int lat, input logic signed [SW-1:0] val, input bit keep, output int g);
    logic [N-1:0] oh;
    board_t       bsnap;
    logic         tsnap;
    g = pick(req_m, ptr_m);
    if (g < 0) begin
      check("txn_has_request", 512'(req_m), 512'(1));
      g = 0;
      return;
    end
    oh    = '0;
    oh[g] = 1'b1;
    bsnap = board_m[g];
    tsnap = turn_m[g];
    @(negedge clk);
    check("start", 512'(sc_start), 512'(1));
    check("grant", 512'(arb_if.grant), 512'(oh));
    check("sc_board", 512'(sc_board), 512'(bsnap));
    check("sc_turn", 512'(sc_turn), 512'(tsnap));
    board_m[g] = rand_board();
    turn_m[g]  = ~turn_m[g];
    ptr_m      = (g + 1) % N;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 0) check("start_pulse", 512'(sc_start), 512'(0));
    end
    sc_finish = 1'b1;
    sc_score  = val;
    @(negedge clk);
    sc_finish = 1'b0;
    sc_score  = $urandom;
    check("done_early", 512'(arb_if.done), 512'(0));
    check("grant_hold", 512'(arb_if.grant), 512'(oh));
    check("board_hold", 512'(sc_board), 512'(bsnap));
    @(negedge clk);
    check("done", 512'(arb_if.done), 512'(oh));
    check("score", 512'(arb_if.score), 512'(val));
    check("grant_clr", 512'(arb_if.grant), 512'(0));
    check("no_timeout", 512'(timeout), 512'(0));
    score_m = val;
    if (!keep) req_m[g] = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_done"}, 512'(arb_if.done), 512'(0));
      check({tag, "_score"}, 512'(arb_if.score), 512'(score_m));
    end
  endtask

  initial begin
    int g;
    req_m     = '0;
    turn_m    = '0;
    sc_finish = 1'b0;
    sc_score  = '0;
    for (int k = 0; k < int'(N); k++) board_m[k] = rand_board();

    repeat (3) @(negedge clk);
    check("rst_grant", 512'(arb_if.grant), 512'(0));
    check("rst_done", 512'(arb_if.done), 512'(0));
    check("rst_score", 512'(arb_if.score), 512'(0));
    check("rst_start", 512'(sc_start), 512'(0));
    check("rst_board", 512'(sc_board), 512'(0));
    check("rst_timeout", 512'(timeout), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single request with a 5-cycle Score unit.
    req_m     = 4'b0010;
    turn_m[1] = 1'b1;
    txn(5, -32'sd37, 1'b0, g);
    check("single_idx", 512'(g), 512'(1));

    // Finish while idle must be ignored.
    @(negedge clk);
    sc_finish = 1'b1;
    sc_score  = 32'sd999;
    @(negedge clk);
    sc_finish = 1'b0;
    check_quiet("spurious");

    // Asynchronous reset in the middle of an evaluation.
    req_m = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 512'(arb_if.grant), 512'(0));
    check("mid_rst_start", 512'(sc_start), 512'(0));
    check("mid_rst_board", 512'(sc_board), 512'(0));
    check("mid_rst_turn", 512'(sc_turn), 512'(0));
    check("mid_rst_score", 512'(arb_if.score), 512'(0));
    req_m   = '0;
    ptr_m   = 0;
    score_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sc_finish = 1'b1;
    sc_score  = 32'sd77;
    @(negedge clk);
    sc_finish = 1'b0;
    check_quiet("post_rst_finish");
    req_m = 4'b1000;
    txn(2, 32'sd12345, 1'b0, g);
    check("post_rst_idx", 512'(g), 512'(3));

    // Fairness: all requesters held high.
    req_m = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      txn(int'($urandom_range(1, 4)), $urandom, 1'b1, g);
      check("fair_idx", 512'(g), 512'(i % 4));
    end

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      req_m = req_m | 4'($urandom_range(0, 15));
      if (req_m == '0) req_m = 4'(1 << $urandom_range(0, 3));
      txn(int'($urandom_range(1, 8)), $urandom, 1'($urandom_range(0, 1)), g);
    end
    req_m = '0;
    @(negedge clk);

`ifdef SCORE_ARB_TIMEOUT_EN
    begin
      logic [N-1:0] oh;
      req_m = 4'(1 << $urandom_range(0, 3));
      g     = pick(req_m, ptr_m);
      oh    = '0;
      oh[g] = 1'b1;
      @(negedge clk);
      check("to_start", 512'(sc_start), 512'(1));
      for (int i = 1; i <= int'(TO); i++) begin
        @(negedge clk);
        check("to_early_done", 512'(arb_if.done), 512'(0));
        check("to_early_flag", 512'(timeout), 512'(0));
      end
      @(negedge clk);
      check("to_done", 512'(arb_if.done), 512'(oh));
      check("to_flag", 512'(timeout), 512'(1));
      check("to_score", 512'(arb_if.score), 512'(0));
      req_m   = '0;
      ptr_m   = (g + 1) % N;
      score_m = '0;
      sc_finish = 1'b1;
      sc_score  = 32'sd55;
      @(negedge clk);
      sc_finish = 1'b0;
      check_quiet("late_finish");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/score_arbiter.md
Name: score_arbiter

Overview:
- Shares one board-evaluation (Score) unit among N_REQ leaf-level search nodes, for example the depth-0 nodes of parallel search lanes.
- Arbitrates requests round-robin and latches the winner's board and turn.
- Pulses the Score unit's start, waits for its finish, then returns the signed score to the winning requester only.
- Sits between the leaf search nodes and a single Score instance, replacing per-node Score copies.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- SCORE_W, 32, signed score width
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with SCORE_ARB_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  N_REQ  per-requester request level; held high until the matching o_done pulse
- i_board  in  N_REQ*450  per-requester board; slice k is bits [k*450 +: 450]; cell c occupies 2 bits at [c*2 +: 2]
- i_turn  in  N_REQ  per-requester side to score for
- o_grant  out  N_REQ  one-hot; high for the whole time requester k owns the unit
- o_done  out  N_REQ  one-hot, single-cycle result-valid pulse
- o_score  out  SCORE_W  signed result; valid when any o_done bit is high, otherwise held
- o_sc_start  out  1  one-cycle start pulse to the Score unit
- o_sc_board  out  450  latched board to the Score unit
- o_sc_turn  out  1  latched turn to the Score unit
- i_sc_score  in  SCORE_W  score from the Score unit
- i_sc_finish  in  1  Score-unit finish pulse
- o_timeout  out  1  watchdog pulse (only with SCORE_ARB_TIMEOUT_EN; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0. Reset is asynchronous and may be asserted mid-operation; it aborts any evaluation in flight. Any Score-unit finish arriving after reset is ignored, because the arbiter is in IDLE and not in WAIT.
- State IDLE:
  - If i_req != 0, pick the first set bit searching upward from the pointer, wrapping modulo N_REQ. Call it g.
  - Register o_grant = onehot(g), o_sc_board = i_board slice g, o_sc_turn = i_turn[g], o_sc_start = 1. Go to ISSUE.
  - The pointer becomes (g+1) mod N_REQ.
- State ISSUE:
  - o_sc_start is high for exactly this one cycle and deasserts on the next.
  - Go to WAIT.
  - o_sc_board and o_sc_turn stay stable from ISSUE until the grant ends.
- State WAIT:
  - On i_sc_finish, capture i_sc_score into o_score, pulse o_done[g] for one cycle, clear o_grant. Go to IDLE.
  - i_sc_finish in any state other than WAIT is ignored.
- Latency: o_done arrives exactly 2 cycles after i_sc_finish rises. Minimum total latency from request to o_done is 3 + Score latency.
- There is one idle bubble between consecutive grants.
- Requester rules:
  - A requester drops i_req in the cycle after its o_done.
  - If it keeps i_req high, that is a new request. It will not be re-granted ahead of other pending requesters, because the pointer has already passed it.
  - Deasserting i_req while granted does not cancel the evaluation; the result is still delivered.
  - Changes to i_board or i_turn after the grant have no effect.
- Simultaneous requests: strict rotation. With all N_REQ requesting continuously, each requester is granted exactly once per N_REQ grants.
- Widths: o_score is passed through unchanged (signed SCORE_W); no arithmetic is applied.

Optional Feature:
- SCORE_ARB_TIMEOUT_EN defined:
  - A 16-bit counter is cleared on entering WAIT and increments every cycle in WAIT.
  - If it reaches TIMEOUT_CYC before i_sc_finish, o_score = 0, and o_done[g] and o_timeout pulse together for one cycle. Go to IDLE.
  - A late i_sc_finish after that is ignored.
- Not defined: no counter; WAIT lasts until i_sc_finish; o_timeout is tied 0.

Decomposition:
- Package gobang_pkg holds:
  - typedef board_t (225 x 2-bit cells) and BOARD_BITS = 450
  - CELL_EMPTY/CELL_BLACK/CELL_WHITE encodings
  - SCORE_W, SCORE_MAX = 32'h7FFF_FFFF, SCORE_MIN = 32'h8000_0001
  - arbiter state enum
- Sub-module rr_pick: combinational. Inputs are req vector and pointer; outputs are the one-hot winner and a found flag. It is instantiated once.

Test Plan:
- Single request: i_req=4'b0010 with Score finishing 5 cycles after start and i_sc_score=-37 -> one o_sc_start pulse, o_grant=4'b0010, then o_done=4'b0010 with o_score=-37 two cycles after finish.
- Fairness: all 4 requesters held high for 8 grants -> grant order 0,1,2,3,0,1,2,3; each o_done goes only to the granted index.
- Board isolation: requester 2 changes i_board slice 2 during WAIT -> o_sc_board stays equal to the value captured at grant.
- Reset mid-operation: i_rst_n low during WAIT -> all outputs 0 immediately. After release, an i_sc_finish with no prior start produces no o_done, and the next i_req=4'b1000 is granted index 3.
- Spurious finish: i_sc_finish pulses while IDLE -> no o_done and o_score unchanged.
- Timeout (SCORE_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): Score never finishes -> o_done[g] and o_timeout pulse together 16 cycles after entering WAIT with o_score=0; a late finish is ignored.
